// File: rtl/dmem_load_store_unit.sv
// MEM-stage load/store unit: one word-aligned data-memory request per access
// over a req/gnt/rvalid handshake, with store lane steering and right-justified
// load return. The pipeline is stalled until the access completes.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, a misaligned
// access is trapped without issuing a request. When it is undefined, the
// address is forced aligned and the access proceeds normally.
module dmem_load_store_unit #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  func3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [1:0]        off_q, off_nx;
  logic              req_nx, we_nx, load_valid_nx, misalign_nx, bus_err_nx;
  logic [31:0]       addr_nx, wdata_nx, load_data_nx;
  logic [3:0]        be_nx;

  logic        access, is_word, is_half, misaligned, timeout_hit;
  logic [1:0]  off_eff;
  logic [3:0]  be_lane;
  logic [31:0] wdata_lane;
  logic        unused_func3_sign;

  // Sign bit of func3 only matters to the downstream extender.
  assign unused_func3_sign = func3_i[2];

  // Access decode: width class, misalignment, aligned lane offset.
  always_comb begin
    access     = mem_read_i | mem_write_i;
    is_word    = func3_i[1];
    is_half    = (func3_i[1:0] == 2'b01);
    misaligned = (is_half & addr_i[0]) | (is_word & (addr_i[1:0] != 2'b00));
    off_eff    = is_word ? 2'b00 : (is_half ? {addr_i[1], 1'b0} : addr_i[1:0]);
    if (is_word) begin
      be_lane    = 4'b1111;
      wdata_lane = wdata_i;
    end else if (is_half) begin
      be_lane    = off_eff[1] ? 4'b1100 : 4'b0011;
      wdata_lane = {2{wdata_i[15:0]}};
    end else begin
      be_lane    = 4'(4'b0001 << off_eff);
      wdata_lane = {4{wdata_i[7:0]}};
    end
  end

  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TIMEOUT_CYC));

  // Pipeline freeze while an access is outstanding; DONE releases for one cycle.
  assign stall_o = access & (state != DONE);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      off_q        <= '0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
      load_data_o  <= '0;
      load_valid_o <= 1'b0;
      misalign_o   <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      off_q        <= off_nx;
      dmem_req_o   <= req_nx;
      dmem_we_o    <= we_nx;
      dmem_addr_o  <= addr_nx;
      dmem_be_o    <= be_nx;
      dmem_wdata_o <= wdata_nx;
      load_data_o  <= load_data_nx;
      load_valid_o <= load_valid_nx;
      misalign_o   <= misalign_nx;
      bus_err_o    <= bus_err_nx;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    off_nx        = off_q;
    req_nx        = dmem_req_o;
    we_nx         = dmem_we_o;
    addr_nx       = dmem_addr_o;
    be_nx         = dmem_be_o;
    wdata_nx      = dmem_wdata_o;
    load_data_nx  = load_data_o;
    load_valid_nx = 1'b0;
    misalign_nx   = 1'b0;
    bus_err_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        if (access) begin
          off_nx = off_eff;
          if (TRAP_EN && misaligned) begin
            state_nx     = DONE;
            misalign_nx  = 1'b1;
            load_data_nx = '0;
          end else begin
            state_nx = REQ;
            cnt_nx   = '0;
            req_nx   = 1'b1;
            we_nx    = mem_write_i;
            addr_nx  = {addr_i[31:2], 2'b00};
            be_nx    = be_lane;
            wdata_nx = mem_write_i ? wdata_lane : 32'h0;
          end
        end
      end
      REQ: begin
        cnt_nx = cnt + CNT_W'(1);
        if (timeout_hit || dmem_gnt_i) begin
          req_nx   = 1'b0;
          we_nx    = 1'b0;
          addr_nx  = '0;
          be_nx    = '0;
          wdata_nx = '0;
        end
        if (timeout_hit) begin
          state_nx     = DONE;
          bus_err_nx   = 1'b1;
          load_data_nx = '0;
        end else if (dmem_gnt_i) begin
          state_nx = dmem_we_o ? DONE : WAIT_R;
        end
      end
      WAIT_R: begin
        cnt_nx = cnt + CNT_W'(1);
        if (timeout_hit) begin
          state_nx     = DONE;
          bus_err_nx   = 1'b1;
          load_data_nx = '0;
        end else if (dmem_rvalid_i) begin
          state_nx      = DONE;
          load_data_nx  = dmem_rdata_i >> {off_q, 3'b000};
          load_valid_nx = 1'b1;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_load_store_unit.sv
// Directed bench for dmem_load_store_unit (TIMEOUT_CYC=8); honours MISALIGN_TRAP_EN.
module tb_dmem_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  func3;
  logic [31:0] addr, wdata;
  logic        stall, load_valid, misalign, bus_err;
  logic [31:0] load_data;
  logic        req, we, gnt, rvalid;
  logic [31:0] maddr, mwdata, rdata;
  logic [3:0]  be;

  int checks = 0;
  int errors = 0;
  int n;

  dmem_load_store_unit #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_i(mem_read), .mem_write_i(mem_write), .func3_i(func3),
    .addr_i(addr), .wdata_i(wdata),
    .stall_o(stall), .load_data_o(load_data), .load_valid_o(load_valid),
    .misalign_o(misalign), .bus_err_o(bus_err),
    .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(maddr), .dmem_be_o(be),
    .dmem_wdata_o(mwdata),
    .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read = 1'b0; mem_write = 1'b0; gnt = 1'b0; rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; idle_inputs();
    func3 = 3'b000; addr = '0; wdata = '0; rdata = '0;
    #12;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_ldata", load_data, 32'h0);
    chk("rst_flags", {29'd0, load_valid, misalign, bus_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: lb 0x103, immediate gnt, rvalid next cycle
    mem_read = 1'b1; func3 = 3'b000; addr = 32'h103; #1;
    chk("lb_stall_idle", 32'(stall), 32'd1);
    tick();
    chk("lb_req", {31'd0, req}, 32'd1);
    chk("lb_addr", maddr, 32'h100);
    chk("lb_be", 32'(be), 32'h8);
    chk("lb_stall_req", 32'(stall), 32'd1);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("lb_req_drop", 32'(req), 32'd0);
    chk("lb_stall_wait", 32'(stall), 32'd1);
    rvalid = 1'b1; rdata = 32'hAABBCCDD;
    tick();
    rvalid = 1'b0;
    chk("lb_stall_done", 32'(stall), 32'd0);
    chk("lb_valid", 32'(load_valid), 32'd1);
    chk("lb_data", load_data, 32'h000000AA);
    mem_read = 1'b0;
    tick();
    chk("lb_valid_pulse", 32'(load_valid), 32'd0);
    chk("lb_data_hold", load_data, 32'h000000AA);

    // 2: sh 0x102
    mem_write = 1'b1; func3 = 3'b001; addr = 32'h102; wdata = 32'h1234ABCD;
    tick();
    chk("sh_we", 32'(we), 32'd1);
    chk("sh_addr", maddr, 32'h100);
    chk("sh_be", 32'(be), 32'hC);
    chk("sh_wdata", mwdata, 32'hABCDABCD);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("sh_done_stall", 32'(stall), 32'd0);
    chk("sh_req_drop", 32'(req), 32'd0);
    mem_write = 1'b0;
    tick();

    // sb 0x101: lane 1
    mem_write = 1'b1; func3 = 3'b000; addr = 32'h101; wdata = 32'hFFFFFF55;
    tick();
    chk("sb_be", 32'(be), 32'h2);
    chk("sb_wdata", mwdata, 32'h55555555);
    gnt = 1'b1;
    tick();
    gnt = 1'b0; mem_write = 1'b0;
    tick();

    // 3: lw 0x200, grant delayed 4 cycles
    mem_read = 1'b1; func3 = 3'b010; addr = 32'h200;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("lw_hold_req", 32'(req), 32'd1);
      chk("lw_hold_addr", maddr, 32'h200);
      chk("lw_hold_be", 32'(be), 32'hF);
      chk("lw_hold_stall", 32'(stall), 32'd1);
      tick();
    end
    gnt = 1'b1;
    tick();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'hDEADBEEF;
    tick();
    rvalid = 1'b0;
    chk("lw_valid", 32'(load_valid), 32'd1);
    chk("lw_data", load_data, 32'hDEADBEEF);
    mem_read = 1'b0;
    tick();

    // lbu 0x101: shift by one byte
    mem_read = 1'b1; func3 = 3'b100; addr = 32'h101;
    tick();
    gnt = 1'b1;
    tick();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'hAABBCCDD;
    tick();
    rvalid = 1'b0;
    chk("lbu_data", load_data, 32'h00AABBCC);
    mem_read = 1'b0;
    tick();

    // 4: lw 0x101 misaligned
    mem_read = 1'b1; func3 = 3'b010; addr = 32'h101;
    tick();
`ifdef MISALIGN_TRAP_EN
    chk("mis_req", 32'(req), 32'd0);
    chk("mis_flag", 32'(misalign), 32'd1);
    chk("mis_stall", 32'(stall), 32'd0);
    chk("mis_data", load_data, 32'h0);
    mem_read = 1'b0;
    tick();
    chk("mis_pulse", 32'(misalign), 32'd0);
`else
    chk("mis_addr", maddr, 32'h100);
    chk("mis_be", 32'(be), 32'hF);
    gnt = 1'b1;
    tick();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h11223344;
    tick();
    rvalid = 1'b0;
    chk("mis_flag", 32'(misalign), 32'd0);
    chk("mis_data", load_data, 32'h11223344);
    mem_read = 1'b0;
    tick();
`endif

    // 5: timeout with TIMEOUT_CYC=8: gnt, no rvalid
    mem_read = 1'b1; func3 = 3'b010; addr = 32'h400; #1;
    n = 0;
    while (stall && n < 30) begin
      n++;
      gnt = (n == 2);
      tick();
    end
    gnt = 1'b0;
    chk("to_stall_cycles", 32'(n), 32'd10);
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_data", load_data, 32'h0);
    chk("to_valid", 32'(load_valid), 32'd0);
    mem_read = 1'b0;
    tick();
    chk("to_err_pulse", 32'(bus_err), 32'd0);

    // preload load_data so reset clearing is observable
    mem_read = 1'b1; addr = 32'h500;
    tick(); gnt = 1'b1; tick(); gnt = 1'b0; rvalid = 1'b1; rdata = 32'h600DF00D;
    tick(); rvalid = 1'b0; mem_read = 1'b0;
    tick();
    chk("pre_data", load_data, 32'h600DF00D);

    // 6: reset in WAIT_R, late rvalid ignored
    mem_read = 1'b1; addr = 32'h300;
    tick(); gnt = 1'b1; tick(); gnt = 1'b0;
    rst_n = 1'b0; mem_read = 1'b0; #1;
    chk("ar_req", 32'(req), 32'd0);
    chk("ar_data", load_data, 32'h0);
    chk("ar_stall", 32'(stall), 32'd0);
    tick();
    rst_n = 1'b1;
    rvalid = 1'b1; rdata = 32'hBADBAD00;
    tick();
    rvalid = 1'b0;
    chk("ar_late_valid", 32'(load_valid), 32'd0);
    chk("ar_late_data", load_data, 32'h0);
    tick();
    mem_read = 1'b1; addr = 32'h304;
    tick(); gnt = 1'b1; tick(); gnt = 1'b0; rvalid = 1'b1; rdata = 32'hCAFEF00D;
    tick(); rvalid = 1'b0;
    chk("ar_next_valid", 32'(load_valid), 32'd1);
    chk("ar_next_data", load_data, 32'hCAFEF00D);
    mem_read = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
